// File: rtl/sonar_sweep_ctrl.sv
// Sonar sweep controller: steps a servo across 8 positions,
// triggers one range measurement per position, reverses at the ends.
//
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   ligar               level enable for sweeping
//   medida_pronto       measurement-complete pulse from ranging unit
//   largura[2:0]        registered servo position code
//   medir               one-cycle measurement trigger
//   posicao_valida      one-cycle strobe: measurement complete
//   timeout             one-cycle strobe: measurement timed out
//   fim_varredura       one-cycle strobe on direction reversal
//   estado_db[2:0]      current FSM state encoding
module sonar_sweep_ctrl #(
  parameter int unsigned DWELL_CYCLES   = 25000000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       medida_pronto,
  output logic [2:0] largura,
  output logic       medir,
  output logic       posicao_valida,
  output logic       timeout,
  output logic       fim_varredura,
  output logic [2:0] estado_db
);

  typedef enum logic [2:0] {
    INICIAL        = 3'd0,
    POSICIONA      = 3'd1,
    ESPERA_SERVO   = 3'd2,
    MEDE           = 3'd3,
    AGUARDA_MEDIDA = 3'd4,
    REGISTRA       = 3'd5,
    PROXIMA        = 3'd6
  } state_t;

  localparam logic [31:0] DWELL_LAST =
    32'(DWELL_CYCLES - 1);
  localparam logic [31:0] TO_LAST =
    32'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [31:0] settle_cnt;
  logic [31:0] wait_cnt;
  logic        dir_up;

  assign estado_db = state;

  // Strobes are registered: each is set on the edge
  // that enters the state in which it must be seen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= INICIAL;
      largura        <= 3'd0;
      dir_up         <= 1'b1;
      settle_cnt     <= 32'd0;
      wait_cnt       <= 32'd0;
      medir          <= 1'b0;
      posicao_valida <= 1'b0;
      timeout        <= 1'b0;
      fim_varredura  <= 1'b0;
    end else begin
      medir          <= 1'b0;
      posicao_valida <= 1'b0;
      timeout        <= 1'b0;
      fim_varredura  <= 1'b0;
      case (state)
        INICIAL: begin
          if (ligar) state <= POSICIONA;
        end
        POSICIONA: begin
          settle_cnt <= 32'd0;
          state      <= ESPERA_SERVO;
        end
        ESPERA_SERVO: begin
          if (settle_cnt == DWELL_LAST) begin
            state <= MEDE;
            medir <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 32'd1;
          end
        end
        MEDE: begin
          wait_cnt <= 32'd0;
          state    <= AGUARDA_MEDIDA;
        end
        AGUARDA_MEDIDA: begin
          // A reply on the last cycle still wins.
          if (medida_pronto) begin
            state          <= REGISTRA;
            posicao_valida <= 1'b1;
          end else if (wait_cnt == TO_LAST) begin
            state   <= REGISTRA;
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        REGISTRA: begin
          state         <= PROXIMA;
          fim_varredura <= dir_up ? (largura == 3'd7)
                                  : (largura == 3'd0);
        end
        PROXIMA: begin
          if (dir_up) begin
            if (largura == 3'd7) begin
              largura <= 3'd6;
              dir_up  <= 1'b0;
            end else begin
              largura <= largura + 3'd1;
            end
          end else begin
            if (largura == 3'd0) begin
              largura <= 3'd1;
              dir_up  <= 1'b1;
            end else begin
              largura <= largura - 3'd1;
            end
          end
          state <= ligar ? POSICIONA : INICIAL;
        end
        default: state <= INICIAL;
      endcase
    end
  end

endmodule

// File: doc/sonar_sweep_ctrl.md
SONAR_SWEEP_CTRL -- requirements
Module: sonar_sweep_ctrl

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 25000000, servo settle cycles per position (>=1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000, maximum cycles waiting for a measurement (>=1).
REQ-003 SHALL have port clock  in  1  clock; all state changes on rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ligar  in  1  enable sweeping; level, synchronous to clock.
REQ-006 SHALL have port medida_pronto  in  1  measurement-complete pulse from ranging unit.
REQ-007 SHALL have port largura  out  3  servo position code driving the PWM generator, registered.
REQ-008 SHALL have port medir  out  1  one-cycle measurement trigger.
REQ-009 SHALL have port posicao_valida  out  1  one-cycle strobe: measurement at largura complete.
REQ-010 SHALL have port timeout  out  1  one-cycle strobe: measurement at largura timed out.
REQ-011 SHALL have port fim_varredura  out  1  one-cycle strobe on sweep direction reversal.
REQ-012 SHALL have port estado_db  out  3  current FSM state encoding.

Function
REQ-013 SHALL implement Moore FSM, encodings: INICIAL=0, POSICIONA=1, ESPERA_SERVO=2, MEDE=3, AGUARDA_MEDIDA=4, REGISTRA=5, PROXIMA=6; codes 7 -> INICIAL next cycle.
REQ-014 INICIAL: ligar=1 -> POSICIONA; else stay; largura held.
REQ-015 POSICIONA: one cycle; clears settle counter; -> ESPERA_SERVO.
REQ-016 ESPERA_SERVO: SHALL remain exactly DWELL_CYCLES cycles (counter 0..DWELL_CYCLES-1), then -> MEDE.
REQ-017 MEDE: medir=1 for this single cycle only; clears timeout counter; -> AGUARDA_MEDIDA.
REQ-018 AGUARDA_MEDIDA: medida_pronto sampled only here; medida_pronto=1 -> REGISTRA (success); else counter==TIMEOUT_CYCLES-1 -> REGISTRA (timeout); else counter+1.
REQ-019 Simultaneous medida_pronto=1 and counter==TIMEOUT_CYCLES-1 SHALL count as success.
REQ-020 REGISTRA: one cycle; posicao_valida=1 on success, timeout=1 on timeout, never both; largura unchanged; -> PROXIMA.
REQ-021 PROXIMA: one cycle; update largura/direction per REQ-022..024; ligar=1 -> POSICIONA, else -> INICIAL.
REQ-022 Direction up: largura<7 -> largura+1; largura==7 -> 6, direction=down, fim_varredura=1.
REQ-023 Direction down: largura>0 -> largura-1; largura==0 -> 1, direction=up, fim_varredura=1.
REQ-024 fim_varredura SHALL assert only in PROXIMA cycles where direction reverses.
REQ-025 ligar deassertion SHALL NOT abort a position in progress; checked only in INICIAL and PROXIMA.
REQ-026 Restart from INICIAL SHALL measure current largura first (no advance); direction retained.
REQ-027 medir, posicao_valida, timeout, fim_varredura SHALL be 0 in all states other than those stated.
REQ-028 Counters SHALL be 32-bit; no wrap within parameter range.

Reset
REQ-029 reset=1 SHALL immediately force: state=INICIAL, largura=000, direction=up, counters=0, all strobes=0, estado_db=0.
REQ-030 reset mid-sweep SHALL discard pending measurement; no strobe emitted for it.

Verification (DWELL_CYCLES=4, TIMEOUT_CYCLES=10)
REQ-031 Reset, ligar=1 at cycle 0 -> POSICIONA cycle 1, ESPERA cycles 2-5, medir=1 cycle 6 only, largura=0.
REQ-032 medida_pronto pulse 3 cycles after medir -> posicao_valida=1 next cycle with largura=0, then largura=1 after PROXIMA.
REQ-033 medida_pronto never arrives -> exactly 10 AGUARDA cycles, timeout=1 one cycle, posicao_valida=0, sweep continues to largura=1.
REQ-034 Full sweep with prompt replies -> largura 0,1..7,6..0,1; fim_varredura exactly once at 7->6 and at 0->1.
REQ-035 ligar dropped during ESPERA at largura=3 -> measurement at 3 completes, advance to 4, state INICIAL; ligar=1 again -> next medir at largura=4.
REQ-036 reset asserted during AGUARDA at largura=5 -> same cycle largura=0, estado_db=0; no posicao_valida/timeout emitted.
